pong_game_ctrl: RTL and testbench

Game-state sequencer for the Pong datapath. It decides when the graphics engine runs or freezes (gra_still), keeps both players' scores, and inserts a timed pause after every point. It detects the winning score and holds the game-over screen until a restart press. It sits between pong_graph (hit/miss pulses in, gra_still out) and the score/font display path. It replaces the ad-hoc freeze register and the separate timer/score glue at top level.

---
 rtl/pong_game_ctrl.sv | 149 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game-state sequencer: freezes/releases the graphics engine, keeps both
// scores and the rally count, times the post-point pause and the game-over hold.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for start press, graphics frozen
//  PLAY  | ball in motion, hits counted, misses score a point
//  PAUSE | frozen for PAUSE_FRAMES frame_ticks after a point
//  OVER  | winner shown; restart accepted once OVER_FRAMES have elapsed
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 120,
    parameter int OVER_FRAMES  = 60,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               hit,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               gra_still,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [7:0]         rally_cnt,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int TMAX = (PAUSE_FRAMES > OVER_FRAMES) ? PAUSE_FRAMES : OVER_FRAMES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]      PAUSE_LOAD = TW'(PAUSE_FRAMES);
    localparam logic [TW-1:0]      OVER_LOAD  = TW'(OVER_FRAMES);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ONE        = SCORE_W'(1);

    state_t         state;
    logic [TW-1:0]  timer;
    logic           btn_s1, btn_s2, btn_d;
    logic           start_p;
    logic [SCORE_W-1:0] left_inc, right_inc;

    assign start_p   = btn_s2 & ~btn_d;
    assign left_inc  = score_left + ONE;
    assign right_inc = score_right + ONE;
    assign state_o   = state;

    // Two-flop synchroniser on the button plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_d  <= 1'b0;
        end else begin
            btn_s1 <= btn_start;
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
        end
    end

    // Game sequencer with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            gra_still   <= 1'b1;
            score_left  <= '0;
            score_right <= '0;
            rally_cnt   <= 8'd0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
            timer       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_p) begin
                        state     <= S_PLAY;
                        rally_cnt <= 8'd0;
                        gra_still <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // miss_left has priority; a miss always overrides a hit
                    if (miss_left) begin
                        score_right <= right_inc;
                        gra_still   <= 1'b1;
                        if (right_inc == WIN) begin
                            state     <= S_OVER;
                            winner    <= 2'b10;
                            game_over <= 1'b1;
                            timer     <= OVER_LOAD;
                        end else begin
                            state <= S_PAUSE;
                            timer <= PAUSE_LOAD;
                        end
                    end else if (miss_right) begin
                        score_left <= left_inc;
                        gra_still  <= 1'b1;
                        if (left_inc == WIN) begin
                            state     <= S_OVER;
                            winner    <= 2'b01;
                            game_over <= 1'b1;
                            timer     <= OVER_LOAD;
                        end else begin
                            state <= S_PAUSE;
                            timer <= PAUSE_LOAD;
                        end
                    end else if (hit && rally_cnt != 8'hFF) begin
                        rally_cnt <= rally_cnt + 8'd1;
                    end
                end
                S_PAUSE: begin
                    if (frame_tick && timer != '0) begin
                        timer <= timer - 1'b1;
                        if (timer == TW'(1)) begin
                            state     <= S_PLAY;
                            rally_cnt <= 8'd0;
                            gra_still <= 1'b0;
                        end
                    end
                end
                S_OVER: begin
                    if (timer == '0) begin
                        if (start_p) begin
                            state       <= S_IDLE;
                            score_left  <= '0;
                            score_right <= '0;
                            winner      <= 2'b00;
                            rally_cnt   <= 8'd0;
                            game_over   <= 1'b0;
                        end
                    end else if (frame_tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3, PAUSE_FRAMES=3, OVER_FRAMES=2.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       hit = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       gra_still;
    logic [3:0] score_left, score_right;
    logic [7:0] rally_cnt;
    logic       game_over;
    logic [1:0] winner;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl #(
        .WIN_SCORE(3), .PAUSE_FRAMES(3), .OVER_FRAMES(2), .SCORE_W(4)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_start(btn_start),
        .hit(hit), .miss_left(miss_left), .miss_right(miss_right),
        .gra_still(gra_still), .score_left(score_left), .score_right(score_right),
        .rally_cnt(rally_cnt), .game_over(game_over), .winner(winner), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one-cycle pulse on a chosen combination of inputs, sampled on the next posedge
    task automatic pulse(input logic h, input logic ml, input logic mr, input logic ft);
        @(negedge clk);
        hit = h; miss_left = ml; miss_right = mr; frame_tick = ft;
        @(negedge clk);
        hit = 1'b0; miss_left = 1'b0; miss_right = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic press(input int n);
        @(negedge clk);
        btn_start = 1'b1;
        repeat (n) @(negedge clk);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // 1: reset and start
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", state_o, 0);
        chk("reset_still", gra_still, 1);
        chk("reset_sl", score_left, 0);
        chk("reset_sr", score_right, 0);
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("start_lag_idle", state_o, 0);
        @(negedge clk);
        chk("start_play", state_o, 1);
        repeat (8) @(negedge clk);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_held_play", state_o, 1);
        chk("start_still", gra_still, 0);

        // 2: rally and first point
        repeat (4) pulse(1, 0, 0, 0);
        chk("rally4", rally_cnt, 4);
        pulse(0, 1, 0, 0);
        chk("p1_sr", score_right, 1);
        chk("p1_state", state_o, 2);
        chk("p1_still", gra_still, 1);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 0, 1);
        chk("pause_2tick", state_o, 2);
        pulse(0, 0, 0, 1);
        chk("pause_done", state_o, 1);
        chk("pause_rally", rally_cnt, 0);
        chk("pause_still", gra_still, 0);

        // 3: simultaneous misses, hit with miss
        pulse(0, 1, 1, 0);
        chk("both_sr", score_right, 2);
        chk("both_sl", score_left, 0);
        // 5: ignored inputs while paused
        pulse(1, 1, 1, 0);
        chk("pause_ign_sr", score_right, 2);
        chk("pause_ign_sl", score_left, 0);
        chk("pause_ign_rally", rally_cnt, 0);
        repeat (3) pulse(0, 0, 0, 1);
        chk("resume2", state_o, 1);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 1, 0);
        chk("hitmiss_sl", score_left, 1);
        chk("hitmiss_rally", rally_cnt, 2);
        repeat (3) pulse(0, 0, 0, 1);
        chk("resume3", state_o, 1);

        // 4: tick coinciding with timer load is not counted
        pulse(0, 0, 1, 1);
        chk("load_tick_sl", score_left, 2);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 0, 1);
        chk("load_tick_still_pause", state_o, 2);
        pulse(0, 0, 0, 1);
        chk("resume4", state_o, 1);
        pulse(0, 0, 1, 0);
        chk("win_sl", score_left, 3);
        chk("win_state", state_o, 3);
        chk("win_over", game_over, 1);
        chk("win_winner", winner, 1);
        press(3);
        chk("early_start0", state_o, 3);
        pulse(0, 0, 0, 1);
        press(3);
        chk("early_start1", state_o, 3);
        pulse(1, 1, 0, 0);
        chk("over_hold_sr", score_right, 2);
        chk("over_hold_winner", winner, 1);
        pulse(0, 0, 0, 1);
        press(3);
        chk("restart_state", state_o, 0);
        chk("restart_sl", score_left, 0);
        chk("restart_sr", score_right, 0);
        chk("restart_winner", winner, 0);
        chk("restart_over", game_over, 0);

        // 5: ignored inputs in IDLE
        pulse(1, 1, 1, 0);
        chk("idle_ign_sr", score_right, 0);
        chk("idle_ign_sl", score_left, 0);
        chk("idle_ign_rally", rally_cnt, 0);
        chk("idle_ign_state", state_o, 0);

        // 6: asynchronous reset mid-pause
        press(3);
        chk("replay", state_o, 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        repeat (3) pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0);
        chk("pre_rst_sr", score_right, 2);
        chk("pre_rst_state", state_o, 2);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_state", state_o, 0);
        chk("async_still", gra_still, 1);
        chk("async_sr", score_right, 0);
        chk("async_sl", score_left, 0);
        chk("async_rally", rally_cnt, 0);
        chk("async_over", game_over, 0);
        chk("async_winner", winner, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
